// File: rtl/lsu_store_buffer.sv
// Store buffer between LSU and DCCM: in-order drain, youngest-entry coalescing, combinational per-byte load forwarding.
// Stores are visible one cycle after accept; st_ready drops only when full and not coalescing, and never looks at dccm_wready_i.
module lsu_store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [XLEN-1:0]            st_addr_i,
  input  logic [XLEN-1:0]            st_data_i,
  input  logic [XLEN/8-1:0]          st_be_i,
  input  logic                       ld_valid_i,
  input  logic [XLEN-1:0]            ld_addr_i,
  output logic [XLEN-1:0]            ld_fwd_data_o,
  output logic [XLEN/8-1:0]          ld_fwd_be_o,
  output logic                       ld_fwd_hit_o,
  output logic                       ld_fwd_full_o,
  output logic                       dccm_wen_o,
  input  logic                       dccm_wready_i,
  output logic [XLEN-1:0]            dccm_waddr_o,
  output logic [XLEN-1:0]            dccm_wdata_o,
  output logic [XLEN/8-1:0]          dccm_wbe_o,
  output logic                       sb_empty_o,
  output logic [$clog2(DEPTH):0]     sb_count_o
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFS_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = XLEN - OFS_W;

  logic [DEPTH-1:0][AW-1:0]   addr_q, addr_d;
  logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;
  logic [DEPTH-1:0][BE_W-1:0] be_q, be_d;
  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]             cnt_q, cnt_d;

  logic [PTR_W-1:0] yng;
  logic [AW-1:0]    st_word, ld_word;
  logic             cnt_nz, head_vld, drain, co_match, accept, do_co, do_alloc;
  logic [PTR_W-1:0] fwd_idx;
  logic [BE_W-1:0]  fwd_be;
  logic [XLEN-1:0]  fwd_dat;
  logic             unused_ofs;

  assign unused_ofs = ^{st_addr_i[OFS_W-1:0], ld_addr_i[OFS_W-1:0]};
  assign st_word    = st_addr_i[XLEN-1:OFS_W];
  assign ld_word    = ld_addr_i[XLEN-1:OFS_W];
  assign yng        = tail_q - PTR_W'(1);
  assign cnt_nz     = (cnt_q != '0);
  assign head_vld   = cnt_nz & vld_q[head_q];
  assign drain      = dccm_wen_o & dccm_wready_i;

  // The youngest entry is only the draining one when it is also the head (count==1).
  assign co_match   = cnt_nz & vld_q[yng] & (addr_q[yng] == st_word) & ~(drain & (yng == head_q));
  assign st_ready_o = (cnt_q < (PTR_W+1)'(DEPTH)) | co_match;
  assign accept     = st_valid_i & st_ready_o;
  assign do_co      = accept & (|st_be_i) & co_match;
  assign do_alloc   = accept & (|st_be_i) & ~co_match;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    vld_d  = vld_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (drain) begin
      vld_d[head_q] = 1'b0;
      be_d[head_q]  = '0;
      head_d        = head_q + PTR_W'(1);
    end
    if (do_co) begin
      for (int b = 0; b < BE_W; b++) begin
        if (st_be_i[b]) data_d[yng][8*b +: 8] = st_data_i[8*b +: 8];
      end
      be_d[yng] = be_q[yng] | st_be_i;
    end
    if (do_alloc) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = st_word;
      data_d[tail_q] = st_data_i;
      be_d[tail_q]   = st_be_i;
      tail_d         = tail_q + PTR_W'(1);
    end
    case ({do_alloc, drain})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      be_q   <= be_d;
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  always_comb begin
    fwd_be  = '0;
    fwd_dat = '0;
    fwd_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (vld_q[fwd_idx] && (addr_q[fwd_idx] == ld_word)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_q[fwd_idx][b]) begin
            fwd_be[b]            = 1'b1;
            fwd_dat[8*b +: 8]    = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign ld_fwd_be_o   = ld_valid_i ? fwd_be : '0;
  assign ld_fwd_data_o = ld_valid_i ? fwd_dat : '0;
  assign ld_fwd_hit_o  = ld_valid_i & (|fwd_be);
  assign ld_fwd_full_o = ld_valid_i & (&fwd_be);

  assign dccm_wen_o   = cnt_nz;
  assign dccm_waddr_o = head_vld ? {addr_q[head_q], {OFS_W{1'b0}}} : '0;
  assign dccm_wdata_o = head_vld ? data_q[head_q] : '0;
  assign dccm_wbe_o   = head_vld ? be_q[head_q] : '0;
  assign sb_empty_o   = ~cnt_nz;
  assign sb_count_o   = cnt_q;
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer: expected DCCM writes are queued at issue and checked by an independent drain monitor.
module tb_lsu_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_be;
  logic        ld_fwd_hit, ld_fwd_full;
  logic        dccm_wen, dccm_wready;
  logic [31:0] dccm_waddr, dccm_wdata;
  logic [3:0]  dccm_wbe;
  logic        sb_empty;
  logic [2:0]  sb_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  lsu_store_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_data_i(st_data), .st_be_i(st_be),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr),
    .ld_fwd_data_o(ld_fwd_data), .ld_fwd_be_o(ld_fwd_be),
    .ld_fwd_hit_o(ld_fwd_hit), .ld_fwd_full_o(ld_fwd_full),
    .dccm_wen_o(dccm_wen), .dccm_wready_i(dccm_wready),
    .dccm_waddr_o(dccm_waddr), .dccm_wdata_o(dccm_wdata), .dccm_wbe_o(dccm_wbe),
    .sb_empty_o(sb_empty), .sb_count_o(sb_count)
  );

  // Drain monitor: every fired DCCM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && dccm_wen && dccm_wready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got write addr=%h data=%h be=%b, required no write",
                 dccm_waddr, dccm_wdata, dccm_wbe);
      end else begin
        e = exp_q.pop_front();
        if (dccm_waddr !== e.a || dccm_wdata !== e.d || dccm_wbe !== e.b) begin
          errors++;
          $display("FAIL drain_order: got addr=%h data=%h be=%b, required addr=%h data=%h be=%b",
                   dccm_waddr, dccm_wdata, dccm_wbe, e.a, e.d, e.b);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit acc = 1'b0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (st_ready) begin acc = 1'b1; break; end
    end
    chk("store_accept_timeout", {63'd0, acc}, 64'd1);
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb_empty) begin done = 1'b1; break; end
    end
    chk(name, {63'd0, done}, 64'd1);
    tick();
  endtask

  task automatic fwd(input string name, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic hit, input logic full);
    ld_valid = 1'b1; ld_addr = a;
    @(negedge clk);
    chk(name, {ld_fwd_data, ld_fwd_be, ld_fwd_hit, ld_fwd_full}, {26'd0, d, b, hit, full});
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    int wen_seen;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; dccm_wready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    @(negedge clk);
    chk("reset_ready_wen_empty_cnt", {st_ready, dccm_wen, sb_empty, sb_count}, {1'b1, 1'b0, 1'b1, 3'd0});
    chk("reset_dccm_fields", {dccm_waddr, dccm_wdata, dccm_wbe}, 68'd0);
    chk("reset_fwd_outputs", {ld_fwd_data, ld_fwd_be, ld_fwd_hit, ld_fwd_full}, 38'd0);
    tick();

    // Zero-byte-enable store is consumed without allocating.
    do_store(32'h600, 32'hFFFF_FFFF, 4'b0000);
    @(negedge clk);
    chk("be0_no_alloc", {sb_empty, sb_count}, {1'b1, 3'd0});
    tick();

    // Fill and stall: the fifth store must wait even while a drain fires.
    for (int i = 0; i < 4; i++) begin
      do_store(32'h10 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'b1111);
      exp_q.push_back('{a: 32'h10 + 32'(4*i), d: 32'h1000_0000 + 32'(i), b: 4'b1111});
    end
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h2020_2020; st_be = 4'b1111;
    exp_q.push_back('{a: 32'h20, d: 32'h2020_2020, b: 4'b1111});
    @(negedge clk);
    chk("full_stall", {st_ready, sb_count}, {1'b0, 3'd4});
    tick();
    dccm_wready = 1'b1;
    @(negedge clk);
    chk("full_stall_during_drain", {63'd0, st_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("ready_after_drain", {st_ready, sb_count}, {1'b1, 3'd3});
    tick();
    st_valid = 1'b0;
    wait_empty("fill_drain_empty");
    dccm_wready = 1'b0;

    // Coalesce two byte stores to the same word.
    do_store(32'h100, 32'h0000_0011, 4'b0001);
    do_store(32'h100, 32'h0000_2200, 4'b0010);
    exp_q.push_back('{a: 32'h100, d: 32'h0000_2211, b: 4'b0011});
    @(negedge clk);
    chk("coalesce_count", {61'd0, sb_count}, 64'd1);
    tick();
    dccm_wready = 1'b1;
    wait_empty("coalesce_empty");
    dccm_wready = 1'b0;

    // Youngest-wins forwarding across non-adjacent entries.
    do_store(32'h200, 32'hAAAA_AAAA, 4'b1111);
    do_store(32'h204, 32'h1234_5678, 4'b1111);
    do_store(32'h200, 32'h0000_00BB, 4'b0001);
    exp_q.push_back('{a: 32'h200, d: 32'hAAAA_AAAA, b: 4'b1111});
    exp_q.push_back('{a: 32'h204, d: 32'h1234_5678, b: 4'b1111});
    exp_q.push_back('{a: 32'h200, d: 32'h0000_00BB, b: 4'b0001});
    fwd("fwd_youngest", 32'h200, 32'hAAAA_AABB, 4'b1111, 1'b1, 1'b1);
    fwd("fwd_other_word", 32'h204, 32'h1234_5678, 4'b1111, 1'b1, 1'b1);
    fwd("fwd_miss", 32'h208, 32'h0, 4'b0000, 1'b0, 1'b0);
    ld_addr = 32'h200;
    @(negedge clk);
    chk("fwd_ld_valid_low", {ld_fwd_data, ld_fwd_be, ld_fwd_hit, ld_fwd_full}, 38'd0);
    tick();
    dccm_wready = 1'b1;
    wait_empty("fwd_empty");
    dccm_wready = 1'b0;

    // Partial forward, still visible while that entry drains.
    do_store(32'h300, 32'h00CC_0000, 4'b0100);
    exp_q.push_back('{a: 32'h300, d: 32'h00CC_0000, b: 4'b0100});
    fwd("fwd_partial", 32'h303, 32'h00CC_0000, 4'b0100, 1'b1, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h300; dccm_wready = 1'b1;
    @(negedge clk);
    chk("fwd_while_draining", {ld_fwd_data, ld_fwd_hit}, {32'h00CC_0000, 1'b1});
    tick();
    @(negedge clk);
    chk("fwd_after_drain", {sb_empty, ld_fwd_hit}, {1'b1, 1'b0});
    tick();
    ld_valid = 1'b0; dccm_wready = 1'b0;

    // Simultaneous allocate and drain, tail wraps past the last slot.
    do_store(32'h400, 32'h0A0A_0A0A, 4'b1111);
    do_store(32'h404, 32'h0B0B_0B0B, 4'b1111);
    exp_q.push_back('{a: 32'h400, d: 32'h0A0A_0A0A, b: 4'b1111});
    exp_q.push_back('{a: 32'h404, d: 32'h0B0B_0B0B, b: 4'b1111});
    exp_q.push_back('{a: 32'h408, d: 32'h0C0C_0C0C, b: 4'b1111});
    exp_q.push_back('{a: 32'h40C, d: 32'h0D0D_0D0D, b: 4'b1111});
    st_valid = 1'b1; st_addr = 32'h408; st_data = 32'h0C0C_0C0C; st_be = 4'b1111;
    dccm_wready = 1'b1;
    @(negedge clk);
    chk("simul_ready_cnt2", {st_ready, sb_count}, {1'b1, 3'd2});
    tick();
    st_addr = 32'h40C; st_data = 32'h0D0D_0D0D;
    @(negedge clk);
    chk("simul_cnt_after_1", {61'd0, sb_count}, 64'd2);
    tick();
    st_valid = 1'b0; dccm_wready = 1'b0;
    @(negedge clk);
    chk("simul_cnt_after_2", {61'd0, sb_count}, 64'd2);
    tick();
    fwd("simul_fwd_wrapped", 32'h408, 32'h0C0C_0C0C, 4'b1111, 1'b1, 1'b1);
    fwd("simul_fwd_tail", 32'h40C, 32'h0D0D_0D0D, 4'b1111, 1'b1, 1'b1);
    dccm_wready = 1'b1;
    wait_empty("simul_empty");
    dccm_wready = 1'b0;

    // Reset mid-operation discards pending entries.
    do_store(32'h500, 32'h5050_5050, 4'b1111);
    do_store(32'h504, 32'h5151_5151, 4'b1111);
    do_store(32'h508, 32'h5252_5252, 4'b1111);
    @(negedge clk);
    chk("midop_cnt3", {61'd0, sb_count}, 64'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dccm_wready = 1'b1;
    @(negedge clk);
    chk("midop_after_reset", {sb_empty, dccm_wen, st_ready, sb_count}, {1'b1, 1'b0, 1'b1, 3'd0});
    tick();
    wen_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (dccm_wen) wen_seen++;
      tick();
    end
    chk("midop_no_dccm_write", 64'(wen_seen), 64'd0);
    fwd("midop_fwd_gone", 32'h500, 32'h0, 4'b0000, 1'b0, 1'b0);

    chk("all_expected_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within bound");
    $fatal(1);
  end
endmodule

// File: doc/lsu_store_buffer.md
LSU_STORE_BUFFER -- requirements
Module: lsu_store_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of store entries; it is a power of 2 and at least 2.
REQ-003 SHALL define BE_W = XLEN/8 and OFS_W = log2(BE_W), both derived and not overridable.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 st_valid  in  1  store request from LSU pipeline.
REQ-007 st_ready  out  1  buffer can accept the store this cycle.
REQ-008 st_addr  in  XLEN  store address; bits [OFS_W-1:0] ignored (word granule).
REQ-009 st_data  in  XLEN  store data, already lane-aligned.
REQ-010 st_be  in  BE_W  store byte enables.
REQ-011 ld_valid  in  1  load lookup request.
REQ-012 ld_addr  in  XLEN  load address; bits [OFS_W-1:0] ignored.
REQ-013 ld_fwd_data  out  XLEN  forwarded bytes.
REQ-014 ld_fwd_be  out  BE_W  bytes supplied by the buffer.
REQ-015 ld_fwd_hit  out  1  at least one byte forwarded.
REQ-016 ld_fwd_full  out  1  all BE_W bytes forwarded; no DCCM read needed.
REQ-017 dccm_wen  out  1  drain write valid.
REQ-018 dccm_wready  in  1  DCCM accepts the write this cycle.
REQ-019 dccm_waddr  out  XLEN  word address, low OFS_W bits zero.
REQ-020 dccm_wdata / dccm_wbe  out  XLEN / BE_W  drain data and byte enables.
REQ-021 sb_empty  out  1  no valid entries (fence/flush qualifier).
REQ-022 sb_count  out  log2(DEPTH)+1  current number of valid entries.

Function
REQ-023 SHALL be a circular FIFO.
- Head/tail pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- count ranges 0..DEPTH.
REQ-024 A store is accepted when st_valid & st_ready; it becomes visible to forwarding and drain from the next cycle.
REQ-025 Coalescing SHALL apply when all of the following hold:
- count>0,
- st_addr word equals the youngest entry's word,
- that entry is not being drained this cycle.
On coalesce, bytes with st_be=1 overwrite, be |= st_be, and no new entry is allocated.
REQ-026 Otherwise an accepted store allocates an entry at tail: tail+1, count+1.
REQ-027 An accepted store with st_be == 0 SHALL be consumed with no state change.
REQ-028 st_ready = (count < DEPTH) | coalesce_hit; st_ready SHALL NOT depend on dccm_wready.
- When full, a non-coalescing store stalls even if a drain fires in the same cycle.
REQ-029 dccm_wen = (count > 0); dccm_waddr, wdata and wbe SHALL be the head entry's registered fields.
REQ-030 A drain fires on dccm_wen & dccm_wready: head+1 and count-1 next cycle.
- Entries drain strictly in allocation order.
REQ-031 Simultaneous allocate and drain SHALL leave count unchanged, with both pointers advancing.
REQ-032 Forwarding SHALL be combinational, in the same cycle as ld_valid, across all valid entries including one draining this cycle.
- Per byte, the youngest entry with be set wins.
- The store accepted in the same cycle is excluded.
REQ-033 Bytes with ld_fwd_be=0 SHALL read 0 in ld_fwd_data.
- ld_fwd_hit = ld_valid & |ld_fwd_be.
- ld_fwd_full = ld_valid & &ld_fwd_be.
- All forwarding outputs are 0 when ld_valid=0.
REQ-034 sb_empty = (count == 0); sb_count = count.
REQ-035 The buffer SHALL hold no X-dependent output.
- Entry fields of invalid slots never affect any output.

Reset
REQ-036 While rst=1, head, tail and count SHALL be 0 and all entry valid/be SHALL be cleared on the next edge.
REQ-037 Reset values: st_ready=1, dccm_wen=0, dccm_waddr/wdata/wbe=0, sb_empty=1, sb_count=0, and all ld_fwd_* = 0.
REQ-038 Reset mid-operation SHALL discard pending entries without writing them; no dccm_wen in the cycle after rst deasserts.

Verification
REQ-039 Fill/stall: with dccm_wready=0, present DEPTH stores to distinct words, then a fifth to a new word.
- Required: sb_count=DEPTH, st_ready=0.
- Raise wready: writes drain in order, one per cycle.
REQ-040 Coalesce: store 0x11 (be=0001) to 0x100, then 0x2200 (be=0010) to 0x100, with wready=0.
- Required: sb_count=1.
- The drain writes wdata low 16 bits 0x2211, wbe=0011.
REQ-041 Forward youngest-wins: entries {0x200: 0xAAAAAAAA be=1111} then {0x204: x}, then {0x200: 0x000000BB be=0001}.
- Required: ld_addr=0x200 gives ld_fwd_data=0xAAAAAABB, ld_fwd_full=1.
REQ-042 Partial forward: a single entry at 0x300 with be=0100, data 0x00CC0000.
- Required: ld_addr=0x303 gives ld_fwd_be=0100, ld_fwd_data=0x00CC0000, hit=1, full=0.
REQ-043 Simultaneous: count=2, accept a store to a new word and a drain in the same cycle.
- Required: count stays 2, pointers wrap correctly across DEPTH boundary.
REQ-044 Reset mid-op: with 3 entries pending, assert rst for 1 cycle.
- Required: sb_empty=1, no DCCM write afterward.
